// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the Memory request arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEFAULT     = 16;
    localparam int unsigned DATA_W_DEFAULT     = 32;
    localparam int unsigned RD_LATENCY_DEFAULT = 1;
    localparam logic [15:0] MEM_TOP_DEFAULT    = 16'h2000;

    // Requester identity: 0 = compute core, 1 = host/loader.
    typedef logic port_id_t;

    // One entry of the read-return pipeline.
    typedef struct packed {
        logic     valid;
        port_id_t id;
        logic     err;
    } rd_tag_t;

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_P0   = 2'd1,
        LOCK_P1   = 2'd2
    } lock_t;

    function automatic lock_t lock_of(input port_id_t id);
        return id ? LOCK_P1 : LOCK_P0;
    endfunction

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Delay line that carries read tags alongside the Memory read latency.
module mem_rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY = RD_LATENCY_DEFAULT
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [RD_LATENCY];

    // Shift tags one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[RD_LATENCY-1];

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data Memory,
// with burst lock, address range checking and tagged read return.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned        ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned        DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned        RD_LATENCY = RD_LATENCY_DEFAULT,
    parameter logic [ADDR_W-1:0]  MEM_TOP    = MEM_TOP_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,

    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    port_id_t          prio;
    lock_t             lock_owner;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] data_hold;

    logic              gnt0, gnt1, granted;
    port_id_t          sel_id;
    logic              sel_we, sel_lock, in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              wr_err;
    rd_tag_t           tag_in, tag_out;
    logic              rv0, rv1;

    // Grant selection: lock holder first, then sole requester, then prio.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (lock_owner == LOCK_P0 && r0_req) begin
                gnt0 = 1'b1;
            end else if (lock_owner == LOCK_P1 && r1_req) begin
                gnt1 = 1'b1;
            end else if (r0_req && r1_req) begin
                if (prio) gnt1 = 1'b1;
                else      gnt0 = 1'b1;
            end else if (r0_req) begin
                gnt0 = 1'b1;
            end else if (r1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign granted   = gnt0 | gnt1;
    assign sel_id    = gnt1;
    assign sel_we    = gnt1 ? r1_we    : r0_we;
    assign sel_lock  = gnt1 ? r1_lock  : r0_lock;
    assign sel_addr  = gnt1 ? r1_addr  : r0_addr;
    assign sel_wdata = gnt1 ? r1_wdata : r0_wdata;
    assign in_range  = sel_addr < MEM_TOP;
    assign wr_err    = granted & sel_we & ~in_range;

    // Memory bus follows the grant and otherwise parks on the last transfer.
    assign mem_address = granted ? sel_addr  : addr_hold;
    assign mem_data    = granted ? sel_wdata : data_hold;
    assign mem_wren    = granted & sel_we & in_range;

    // Round-robin pointer, burst lock and parked bus values.
    // A lock whose owner stops requesting is released even with no transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio       <= 1'b0;
            lock_owner <= LOCK_NONE;
            addr_hold  <= '0;
            data_hold  <= '0;
        end else if (granted) begin
            prio       <= ~sel_id;
            lock_owner <= sel_lock ? lock_of(sel_id) : LOCK_NONE;
            addr_hold  <= sel_addr;
            data_hold  <= sel_wdata;
        end else if ((lock_owner == LOCK_P0 && !r0_req) ||
                     (lock_owner == LOCK_P1 && !r1_req)) begin
            lock_owner <= LOCK_NONE;
        end
    end

    assign tag_in = '{valid: granted & ~sel_we, id: sel_id, err: ~in_range};

    mem_rd_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rd_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign rv0 = ~reset & tag_out.valid & (tag_out.id == 1'b0);
    assign rv1 = ~reset & tag_out.valid & (tag_out.id == 1'b1);

    assign r0_gnt    = gnt0;
    assign r1_gnt    = gnt1;
    assign r0_rvalid = rv0;
    assign r1_rvalid = rv1;
    assign r0_rdata  = (rv0 && !tag_out.err) ? mem_q : '0;
    assign r1_rdata  = (rv1 && !tag_out.err) ? mem_q : '0;
    assign r0_err    = (gnt0 & wr_err) | (rv0 & tag_out.err);
    assign r1_err    = (gnt1 & wr_err) | (rv1 & tag_out.err);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a behavioural Memory and a read scoreboard.
module tb_mem_req_arbiter;

    localparam int unsigned LAT = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
    logic [15:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic [15:0] mem_address;
    logic [31:0] mem_data, mem_q;
    logic        mem_wren;

    mem_req_arbiter #(.RD_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
        .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
        .r1_rdata(r1_rdata), .r1_err(r1_err),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural Memory: registered read, LAT cycles, read-after-write.
    logic [31:0] mem [0:65535];
    logic [31:0] qp  [LAT];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        qp[0] <= mem[mem_address];
        for (int i = 1; i < LAT; i++) qp[i] <= qp[i-1];
    end
    assign mem_q = qp[LAT-1];

    typedef struct {
        bit          port;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] shadow [0:65535];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit port, input logic [31:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.data = data;
        e.err  = err;
        e.cyc  = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic idle();
        r0_req = 0; r0_we = 0; r0_lock = 0;
        r1_req = 0; r1_we = 0; r1_lock = 0;
    endtask

    // Read-return monitor: pops the scoreboard on every rvalid.
    always begin
        exp_t e;
        @(negedge clock);
        #3;
        if (r0_rvalid || r1_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {31'd0, r0_rvalid | r1_rvalid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rv0", {31'd0, r0_rvalid}, {31'd0, !e.port});
                chk("rv1", {31'd0, r1_rvalid}, {31'd0, e.port});
                chk("rdata", e.port ? r1_rdata : r0_rdata, e.data);
                chk("rdata_other", e.port ? r0_rdata : r1_rdata, 32'd0);
                chk("rerr", {31'd0, e.port ? r1_err : r0_err}, {31'd0, e.err});
                chk("rlatency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] a0, a1;
        idle();
        r0_addr = 0; r1_addr = 0; r0_wdata = 0; r1_wdata = 0;
        reset = 1;
        // Reset state, with a request pending that must not be granted.
        r0_req = 1; r0_we = 1; r0_addr = 16'h0010; r0_wdata = 32'h1234;
        @(negedge clock); #1;
        chk("rst_gnt0", {31'd0, r0_gnt}, 0);
        chk("rst_wren", {31'd0, mem_wren}, 0);
        chk("rst_addr", {16'd0, mem_address}, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_rvalid", {30'd0, r0_rvalid, r1_rvalid}, 0);
        chk("rst_err", {30'd0, r0_err, r1_err}, 0);
        @(negedge clock);
        reset = 0; idle();

        // Write then read the same address.
        @(negedge clock);
        r0_req = 1; r0_we = 1; r0_addr = 16'h0010; r0_wdata = 32'hDEADBEEF; #1;
        chk("t1_wgnt", {31'd0, r0_gnt}, 1);
        chk("t1_wren", {31'd0, mem_wren}, 1);
        chk("t1_waddr", {16'd0, mem_address}, 32'h10);
        chk("t1_wdata", mem_data, 32'hDEADBEEF);
        shadow[16'h0010] = 32'hDEADBEEF;
        @(negedge clock);
        r0_we = 0; #1;
        chk("t1_rgnt", {31'd0, r0_gnt}, 1);
        chk("t1_rwren", {31'd0, mem_wren}, 0);
        push(0, shadow[16'h0010], 0);
        @(negedge clock);
        idle(); #1;
        chk("t1_hold_addr", {16'd0, mem_address}, 32'h10);
        chk("t1_idle_gnt", {30'd0, r0_gnt, r1_gnt}, 0);
        repeat (LAT + 1) @(negedge clock);

        // Seed four words for the alternating-read test.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            r0_req = 1; r0_we = 1; r0_addr = 16'h0020 + 16'(i); r0_wdata = 32'hC0DE0000 + i; #1;
            chk("seed_gnt", {31'd0, r0_gnt}, 1);
            shadow[16'h0020 + 16'(i)] = 32'hC0DE0000 + i;
        end
        @(negedge clock); idle(); reset = 1;
        @(negedge clock); reset = 0;

        // Both ports reading continuously: alternate grants, back-to-back returns.
        a0 = 16'h0020; a1 = 16'h0021;
        for (int k = 0; k < 4 + LAT; k++) begin
            @(negedge clock);
            if (k < 4) begin
                r0_req = 1; r0_we = 0; r0_addr = a0;
                r1_req = 1; r1_we = 0; r1_addr = a1;
            end else begin
                idle();
            end
            #1;
            if (k < 4) begin
                chk("t2_gnt0", {31'd0, r0_gnt}, {31'd0, (k % 2) == 0});
                chk("t2_gnt1", {31'd0, r1_gnt}, {31'd0, (k % 2) == 1});
                if ((k % 2) == 0) begin push(0, shadow[a0], 0); a0 = a0 + 2; end
                else              begin push(1, shadow[a1], 0); a1 = a1 + 2; end
            end
            chk("t2_rv_any", {31'd0, r0_rvalid | r1_rvalid}, {31'd0, k >= LAT && k < 4 + LAT});
        end
        repeat (2) @(negedge clock);

        // Port 1 burst-locks three writes while port 0 waits.
        @(negedge clock);
        r1_req = 1; r1_we = 1; r1_lock = 1; r1_addr = 16'h0100; r1_wdata = 32'h11110000; #1;
        chk("t3_c1_gnt1", {31'd0, r1_gnt}, 1);
        chk("t3_c1_wren", {31'd0, mem_wren}, 1);
        @(negedge clock);
        r0_req = 1; r0_we = 1; r0_addr = 16'h0104; r0_wdata = 32'h22220000;
        r1_addr = 16'h0101; #1;
        chk("t3_c2_gnt1", {31'd0, r1_gnt}, 1);
        chk("t3_c2_gnt0", {31'd0, r0_gnt}, 0);
        @(negedge clock);
        r1_addr = 16'h0102; r1_lock = 0; #1;
        chk("t3_c3_gnt1", {31'd0, r1_gnt}, 1);
        chk("t3_c3_gnt0", {31'd0, r0_gnt}, 0);
        @(negedge clock);
        r1_addr = 16'h0103; #1;
        chk("t3_c4_gnt0", {31'd0, r0_gnt}, 1);
        chk("t3_c4_gnt1", {31'd0, r1_gnt}, 0);
        chk("t3_c4_addr", {16'd0, mem_address}, 32'h104);
        @(negedge clock);
        r0_req = 0; #1;
        chk("t3_c5_gnt1", {31'd0, r1_gnt}, 1);
        @(negedge clock); idle();

        // Range boundary: last legal word, first illegal word, far illegal read.
        @(negedge clock);
        r0_req = 1; r0_we = 1; r0_addr = 16'h1FFF; r0_wdata = 32'h5A5A5A5A; #1;
        chk("t4_1fff_wren", {31'd0, mem_wren}, 1);
        chk("t4_1fff_err", {31'd0, r0_err}, 0);
        @(negedge clock);
        r0_addr = 16'h2000; #1;
        chk("t4_2000_gnt", {31'd0, r0_gnt}, 1);
        chk("t4_2000_err", {31'd0, r0_err}, 1);
        chk("t4_2000_wren", {31'd0, mem_wren}, 0);
        @(negedge clock);
        r0_we = 0; r0_addr = 16'hFFFF; #1;
        chk("t4_ffff_gnt", {31'd0, r0_gnt}, 1);
        chk("t4_ffff_err_early", {31'd0, r0_err}, 0);
        push(0, 32'd0, 1);
        @(negedge clock); idle();
        repeat (LAT + 1) @(negedge clock);

        // Reads in flight are dropped by a reset pulse; prio returns to 0.
        @(negedge clock);
        r1_req = 1; r1_we = 0; r1_addr = 16'h0021; #1;
        chk("t5_gnt1", {31'd0, r1_gnt}, 1);
        @(negedge clock);
        r1_req = 0; r0_req = 1; r0_we = 0; r0_addr = 16'h0020; #1;
        chk("t5_gnt0", {31'd0, r0_gnt}, 1);
        @(negedge clock);
        idle(); reset = 1; #1;
        chk("t5_rst_addr", {16'd0, mem_address}, 0);
        chk("t5_rst_wren", {31'd0, mem_wren}, 0);
        @(negedge clock);
        reset = 0;
        r0_req = 1; r0_we = 0; r0_addr = 16'h0022;
        r1_req = 1; r1_we = 0; r1_addr = 16'h0023; #1;
        chk("t5_post_gnt0", {31'd0, r0_gnt}, 1);
        chk("t5_post_gnt1", {31'd0, r1_gnt}, 0);
        push(0, shadow[16'h0022], 0);
        @(negedge clock);
        r0_req = 0; #1;
        chk("t5_next_gnt1", {31'd0, r1_gnt}, 1);
        push(1, shadow[16'h0023], 0);
        @(negedge clock); idle();
        repeat (LAT + 1) @(negedge clock);

        // Quiet period.
        for (int k = 0; k < 10; k++) begin
            @(negedge clock); #1;
            chk("t6_wren", {31'd0, mem_wren}, 0);
            chk("t6_gnt", {30'd0, r0_gnt, r1_gnt}, 0);
            chk("t6_rvalid", {30'd0, r0_rvalid, r1_rvalid}, 0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single-port banked data Memory (16-bit address, 32-bit data, wren, registered q) between two requesters: port 0 (matrix compute core) and port 1 (host/loader).
- Round-robin arbitration with optional burst lock, address range checking and a read-return pipeline that tags data to the issuing port.
- Sits between the requesters and Memory; owns every Memory control input.

Parameters:
- ADDR_W, 16, request and Memory address width.
- DATA_W, 32, data width.
- RD_LATENCY, 1, Memory cycles from address presented to q valid (1..4).
- MEM_TOP, 16'h2000, first illegal address; legal range is 0..MEM_TOP-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rN_req  in  1  request valid for port N, N=0,1.
- rN_we  in  1  1=write, 0=read.
- rN_lock  in  1  hold grant for the next request (burst).
- rN_addr  in  ADDR_W  request address.
- rN_wdata  in  DATA_W  write data.
- rN_gnt  out  1  request accepted this cycle.
- rN_rvalid  out  1  read data valid for port N.
- rN_rdata  out  DATA_W  read data.
- rN_err  out  1  pulses with gnt (writes) or with rvalid (reads) on an out-of-range access.
- mem_address  out  ADDR_W  to Memory address.
- mem_data  out  DATA_W  to Memory data.
- mem_wren  out  1  to Memory wren.
- mem_q  in  DATA_W  from Memory q.

Behaviour:
- Reset (async, active-high):
  - prio=0, lock_owner=none, read pipeline cleared.
  - While reset is high: all gnt, rvalid and err are 0; mem_wren=0; mem_address=0; mem_data=0.
- Grant is combinational, same cycle as req. At most one gnt per cycle. A transfer occurs when rN_req and rN_gnt are both 1.
- Arbitration, evaluated in order:
  1. If lock_owner=N and rN_req=1, grant N.
  2. If lock_owner=N and rN_req=0, release the lock and arbitrate normally this cycle.
  3. If only one port requests, grant it.
  4. If both ports request, grant port prio.
- Register update on each transfer by port N:
  - prio <= ~N.
  - lock_owner <= N if rN_lock=1, otherwise none.
- With no transfer, prio and lock_owner hold.
- Memory drive:
  - mem_address and mem_data carry the granted port's addr/wdata.
  - mem_wren = granted & we & in_range.
  - With no grant: mem_wren=0; mem_address and mem_data hold their last values (no glitching to requesters).
- Range check: in_range = addr < MEM_TOP.
  - Out-of-range write: granted, mem_wren suppressed, rN_err=1 in the grant cycle.
  - Out-of-range read: granted, then returns rdata=0 with err=1 at the normal latency.
- Read return:
  - Every granted read pushes {valid, id, err} into a RD_LATENCY-deep shift pipeline.
  - Exactly RD_LATENCY cycles after the grant, rID_rvalid=1 for one cycle and rID_rdata = err ? 0 : mem_q.
  - The port not addressed sees rvalid=0 and rdata=0.
  - Back-to-back reads are fully pipelined at one per cycle, with no bubbles.
- Write-then-read to the same address in consecutive cycles returns the new data; Memory is read-after-write, so the arbiter adds no hazard logic.
- Reset asserted mid-flight: all in-flight reads are dropped, never returned; lock is released.
- A request is held stable by the requester until gnt; the arbiter does not latch ungranted requests.

Decomposition:
- Package mem_arb_pkg: ADDR_W, DATA_W, MEM_TOP, RD_LATENCY defaults; port-id type (1 bit); struct rd_tag_t {valid, id, err}; lock_owner encoding (NONE, P0, P1).
- Sub-module mem_rd_tag_pipe: parameterised RD_LATENCY shift register of rd_tag_t with async reset. The top level holds arbitration, lock, range check and muxing.

Test Plan:
- Port0 write addr 16'h0010 data 32'hDEADBEEF, then read 16'h0010 → r0_gnt=1 both cycles; mem_wren=1 on the first only; r0_rvalid=1 with r0_rdata=32'hDEADBEEF RD_LATENCY cycles after the read grant.
- Both ports request reads continuously from reset → grants alternate 0,1,0,1; each rvalid goes to the correct port; 4 reads complete in 4 consecutive cycles.
- Port1 holds lock for 3 writes while port0 requests → r1_gnt on 3 consecutive cycles, port0 starved; on the cycle port1 drops lock, r0_gnt=1 next.
- Port0 write to 16'h2000 (=MEM_TOP) → r0_gnt=1, r0_err=1, mem_wren=0. A read of 16'hFFFF returns rdata=0 with r0_err=1 alongside rvalid.
- RD_LATENCY=3: issue 2 reads, assert reset for 1 cycle mid-flight → no rvalid afterwards. After release, prio=0, so a simultaneous request grants port0.
- Idle with no requests for 10 cycles → mem_wren stays 0, no gnt, no rvalid.
